// File: rtl/adaptive_filter_pkg.sv
// Shared definitions for the adaptive filter and its capture/readout path.
//   WORDLENGTH              - sample width used by the filter datapath
//   CAPTURE_DEPTH_DEFAULT   - default number of samples per captured frame
//   SETTLE_SAMPLES_DEFAULT  - default valid samples dropped after arm
//   capture_state_t         - capture reader FSM states
package adaptive_filter_pkg;

  localparam int WORDLENGTH             = 14;
  localparam int CAPTURE_DEPTH_DEFAULT  = 128;
  localparam int SETTLE_SAMPLES_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
//   i_clk      - clock
//   i_wr_en    - write strobe
//   i_wr_addr  - write address
//   i_wr_data  - write data
//   i_rd_en    - read strobe; o_rd_data updates only when set, else holds
//   i_rd_addr  - read address
//   o_rd_data  - read data, one cycle after i_rd_en
module capture_ram #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 128
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/filter_capture_reader.sv
// Captures one frame of adaptive-filter output samples into a buffer and
// plays it back on a ready/valid stream with tlast.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for arm; s_tvalid ignored
// SETTLE  | dropping the first SETTLE_SAMPLES valid samples
// CAPTURE | storing each valid sample at wr_ptr until the buffer is full
// READOUT | streaming the buffer out; returns to IDLE after tlast handshake
//
// Ports:
//   clk, srst            - clock, asynchronous active-high reset
//   arm                  - start a frame (honoured in IDLE only)
//   s_tdata, s_tvalid    - filter output stream, no backpressure
//   m_tdata, m_tvalid,
//   m_tready, m_tlast    - readout stream
//   busy                 - any state other than IDLE
//   frame_done           - one-cycle pulse after the final readout handshake
module filter_capture_reader
  import adaptive_filter_pkg::*;
#(
  parameter int CAPTURE_DEPTH  = CAPTURE_DEPTH_DEFAULT,
  parameter int SETTLE_SAMPLES = SETTLE_SAMPLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  arm,
  input  logic [WORDLENGTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic [WORDLENGTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int AW = $clog2(CAPTURE_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(CAPTURE_DEPTH - 1);

  // Settle counter is a down-counter loaded on arm; terminal count is zero.
  localparam int SETTLE_W      = (SETTLE_SAMPLES > 2) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int SETTLE_LOAD_I = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_LOAD_I);

  capture_state_t r_state, w_state_nxt;

  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic                  r_rd_done;
  logic                  r_p_valid;
  logic                  r_p_last;
  logic [WORDLENGTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_frame_done;

  logic [WORDLENGTH-1:0] w_ram_rdata;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_adv;
  logic                  w_last_xfer;

  // The readout path is a two-stage pipeline (RAM read register, output
  // register) that advances as a whole whenever the output slot is free or
  // being taken. A stall freezes both stages, so nothing is lost or doubled.
  assign w_adv       = (r_state == READOUT) && (!r_m_tvalid || m_tready);
  assign w_last_xfer = r_m_tvalid && m_tready && r_m_tlast;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          if (SETTLE_SAMPLES == 0) w_state_nxt = CAPTURE;
          else                     w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (s_tvalid && (r_settle_cnt == '0)) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (s_tvalid) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == LAST_IDX) w_state_nxt = READOUT;
        end
      end
      READOUT: begin
        w_rd_en = w_adv && !r_rd_done;
        if (w_last_xfer) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_settle_cnt <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_done    <= 1'b0;
      r_p_valid    <= 1'b0;
      r_p_last     <= 1'b0;
      r_m_tdata    <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if ((r_state == IDLE) && arm)
        r_settle_cnt <= SETTLE_LOAD;
      else if ((r_state == SETTLE) && s_tvalid && (r_settle_cnt != '0))
        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);

      // Pointers wrap naturally to 0 after index CAPTURE_DEPTH-1.
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        if (r_rd_ptr == LAST_IDX) r_rd_done <= 1'b1;
      end

      if (w_adv) begin
        r_p_valid  <= w_rd_en;
        r_p_last   <= w_rd_en && (r_rd_ptr == LAST_IDX);
        r_m_tvalid <= r_p_valid;
        r_m_tlast  <= r_p_last;
        if (r_p_valid) r_m_tdata <= w_ram_rdata;
      end

      if (w_last_xfer) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
        r_p_valid  <= 1'b0;
        r_p_last   <= 1'b0;
        r_rd_done  <= 1'b0;
      end

      r_frame_done <= w_last_xfer;
    end
  end

  capture_ram #(
    .WIDTH (WORDLENGTH),
    .DEPTH (CAPTURE_DEPTH)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_tdata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rdata)
  );

  assign m_tdata    = r_m_tdata;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;

endmodule
